// File: rtl/modmul_arbiter.sv
// modmul_arbiter: round-robin sequencer sharing one mod-3329 multiplier among N_REQ requesters.
// Define MODMUL_ARB_WDOG_EN to compile in the WAIT-state watchdog abort.
module modmul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WDOG_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [12*N_REQ-1:0] a_in_i,
    input  logic [12*N_REQ-1:0] b_in_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rsp_valid_o,
    output logic [11:0]         rsp_r_o,
    output logic                rsp_err_o,
    output logic                arb_busy_o,
    output logic                mm_en_o,
    output logic [11:0]         mm_a_o,
    output logic [11:0]         mm_b_o,
    input  logic                mm_busy_i,
    input  logic                mm_done_i,
    input  logic [11:0]         mm_r_i
);

    localparam int DATA_W = 12;
    localparam int IDX_W  = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic [DATA_W-1:0]   rsp_r_q;
    logic                busy_q;
    logic                mm_en_q;
    logic [DATA_W-1:0]   mm_a_q;
    logic [DATA_W-1:0]   mm_b_q;

    logic                win_vld_d;
    logic [IDX_W-1:0]    win_idx_d;
    logic [DATA_W-1:0]   win_a_d;
    logic [DATA_W-1:0]   win_b_d;

`ifdef MODMUL_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0]     wdog_q;
    logic                rsp_err_q;
    assign rsp_err_o = rsp_err_q;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (WDOG_CYCLES > 0);
    assign rsp_err_o       = 1'b0;
`endif

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_REQ - 1)) next_ptr = '0;
        else                          next_ptr = idx + 1'b1;
    endfunction

    // Scan downward in offset so the requester closest above ptr is assigned last and wins.
    always_comb begin
        int j;
        j         = 0;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        win_a_d   = '0;
        win_b_d   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_i[j]) begin
                win_vld_d = 1'b1;
                win_idx_d = IDX_W'(j);
                win_a_d   = a_in_i[DATA_W*j +: DATA_W];
                win_b_d   = b_in_i[DATA_W*j +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            busy_q      <= 1'b0;
            mm_en_q     <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
`ifdef MODMUL_ARB_WDOG_EN
            wdog_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        owner_q <= win_idx_d;
                        mm_a_q  <= win_a_d;
                        mm_b_q  <= win_b_d;
                        gnt_q   <= onehot(win_idx_d);
                        mm_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                // en is held until the multiplier is free, so a job still running
                // after a watchdog abort delays the next issue.
                ISSUE: begin
                    if (!mm_busy_i) begin
                        mm_en_q <= 1'b0;
                        state_q <= WAIT;
`ifdef MODMUL_ARB_WDOG_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mm_done_i) begin
                        rsp_r_q     <= mm_r_i;
                        rsp_valid_q <= onehot(owner_q);
                        state_q     <= RESP;
`ifdef MODMUL_ARB_WDOG_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                        rsp_r_q     <= '0;
                        rsp_valid_q <= onehot(owner_q);
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q      <= wdog_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
`ifdef MODMUL_ARB_WDOG_EN
                    rsp_err_q   <= 1'b0;
`endif
                    ptr_q       <= next_ptr(owner_q);
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_r_o     = rsp_r_q;
    assign arb_busy_o  = busy_q;
    assign mm_en_o     = mm_en_q;
    assign mm_a_o      = mm_a_q;
    assign mm_b_o      = mm_b_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a behavioural 5-edge mod-3329 multiplier model.
module tb_modmul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [47:0] a_in, b_in;
    logic [3:0]  gnt, rsp_valid;
    logic [11:0] rsp_r;
    logic        rsp_err, arb_busy, mm_en;
    logic [11:0] mm_a, mm_b;
    logic        mm_busy, mm_done;
    logic [11:0] mm_r;

    // multiplier model state
    logic        stall;
    logic [2:0]  m_cnt;
    logic [11:0] m_a, m_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modmul_arbiter #(.N_REQ(4), .WDOG_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .a_in_i(a_in), .b_in_i(b_in),
        .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_r_o(rsp_r), .rsp_err_o(rsp_err),
        .arb_busy_o(arb_busy), .mm_en_o(mm_en), .mm_a_o(mm_a), .mm_b_o(mm_b),
        .mm_busy_i(mm_busy), .mm_done_i(mm_done), .mm_r_i(mm_r)
    );

    // Accepts en while idle; done is high in the cycle after the 5th edge following acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_busy <= 1'b0; mm_done <= 1'b0; mm_r <= '0; m_cnt <= '0; m_a <= '0; m_b <= '0;
        end else if (!mm_busy) begin
            mm_done <= 1'b0;
            if (mm_en) begin
                mm_busy <= 1'b1; m_cnt <= '0; m_a <= mm_a; m_b <= mm_b;
            end
        end else if (stall) begin
            mm_done <= 1'b0;
        end else if (mm_done) begin
            mm_done <= 1'b0; mm_busy <= 1'b0;
        end else if (m_cnt == 3'd4) begin
            mm_done <= 1'b1;
            mm_r    <= 12'((int'(m_a) * int'(m_b)) % 3329);
        end else begin
            m_cnt <= m_cnt + 3'd1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        a_in[12*i +: 12] = a;
        b_in[12*i +: 12] = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},  gnt, 0);
        chk({tag, ".rspv"}, rsp_valid, 0);
        chk({tag, ".rspr"}, rsp_r, 0);
        chk({tag, ".err"},  rsp_err, 0);
        chk({tag, ".busy"}, arb_busy, 0);
        chk({tag, ".en"},   mm_en, 0);
        chk({tag, ".ab"},   {mm_a, mm_b}, 0);
    endtask

    // One full transaction from an idle arbiter: E0 grant, E1 issue, E7 response, E8 idle.
    task automatic job(input int idx, input logic [3:0] reqv, input logic [11:0] a,
                       input logic [11:0] b, input logic [11:0] exp_r, input string tag);
        set_op(idx, a, b);
        req = reqv;
        step();
        chk({tag, ".gnt"}, gnt, 4'(1 << idx));
        chk({tag, ".en0"}, mm_en, 1);
        chk({tag, ".a"}, mm_a, a);
        chk({tag, ".b"}, mm_b, b);
        req  = '0;
        a_in = ~a_in;
        b_in = ~b_in;
        step();
        chk({tag, ".en1"}, mm_en, 0);
        chk({tag, ".a_hold"}, mm_a, a);
        repeat (5) step();
        chk({tag, ".early"}, rsp_valid, 0);
        step();
        chk({tag, ".rspv"}, rsp_valid, 4'(1 << idx));
        chk({tag, ".rspr"}, rsp_r, exp_r);
        chk({tag, ".err"}, rsp_err, 0);
        step();
        chk({tag, ".rspv_clr"}, rsp_valid, 0);
        chk({tag, ".idle"}, arb_busy, 0);
        chk({tag, ".rspr_hold"}, rsp_r, exp_r);
    endtask

    initial begin
        int ng, seen, lat;
        int g_idx[5];
        int g_cyc[5];
        logic prev_busy;

        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; stall = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        job(0, 4'b0001, 12'd1234, 12'd2,    12'd2468, "j0");
        job(2, 4'b0100, 12'd3328, 12'd3328, 12'd1,    "j2_max");
        job(2, 4'b0100, 12'd2000, 12'd2000, 12'd1871, "j2_wrap");
        job(0, 4'b0101, 12'd7,    12'd9,    12'd63,   "ptr3_wrap");
        job(2, 4'b0101, 12'd100,  12'd33,   12'd3300, "ptr1_rr");

        // req = 1111 held from reset
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 4; i++) set_op(i, 12'(i + 10), 12'd3);
        req = 4'b1111;
        rst_n = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            prev_busy = arb_busy;
            step();
            if (gnt != 0) begin
                chk("held.busy_before_gnt", prev_busy, 0);
                for (int i = 0; i < 4; i++) if (gnt[i]) g_idx[ng] = i;
                g_cyc[ng] = c;
                ng++;
            end
        end
        req = '0;
        chk("held.ngrants", ng, 5);
        chk("held.g0", g_idx[0], 0);
        chk("held.g1", g_idx[1], 1);
        chk("held.g2", g_idx[2], 2);
        chk("held.g3", g_idx[3], 3);
        chk("held.g4", g_idx[4], 0);
        for (int i = 1; i < 5; i++) chk("held.spacing", g_cyc[i] - g_cyc[i-1], 9);
        repeat (9) step();
        chk("held.idle", arb_busy, 0);

        // stalled multiplier, reset during WAIT (ptr is 1 here)
        stall = 1'b1;
        set_op(2, 12'd5, 12'd5);
        req = 4'b0100;
        step();
        chk("stall.gnt", gnt, 4'b0100);
        req = '0;
        seen = 0;
        repeat (12) begin
            step();
            if (rsp_valid != 0) seen++;
        end
        chk("stall.no_rsp", seen, 0);
        chk("stall.busy", arb_busy, 1);
        chk("stall.en", mm_en, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        stall = 1'b0;
        seen = 0;
        repeat (3) begin
            step();
            if (rsp_valid != 0) seen++;
        end
        chk("rst_wait.no_rsp", seen, 0);
        rst_n = 1'b1;
        step();
        job(0, 4'b1001, 12'd5, 12'd6, 12'd30, "post_rst");

`ifdef MODMUL_ARB_WDOG_EN
        // watchdog abort (ptr is 1 here)
        stall = 1'b1;
        set_op(1, 12'd11, 12'd12);
        req = 4'b0010;
        step();
        chk("wd.gnt", gnt, 4'b0010);
        req = '0;
        lat = 0;
        while (rsp_valid == 0 && lat < 40) begin
            step();
            lat++;
        end
        chk("wd.latency", lat, 16);
        chk("wd.rspv", rsp_valid, 4'b0010);
        chk("wd.err", rsp_err, 1);
        chk("wd.rspr", rsp_r, 0);
        step();
        chk("wd.rspv_clr", {rsp_valid, rsp_err}, 0);
        set_op(0, 12'd3, 12'd4);
        req = 4'b0001;
        step();
        chk("wd.next_gnt", gnt, 4'b0001);
        req = '0;
        repeat (3) step();
        chk("wd.en_held", mm_en, 1);
        stall = 1'b0;
        lat = 0;
        while (rsp_valid == 0 && lat < 40) begin
            step();
            lat++;
        end
        chk("wd.next_rspv", rsp_valid, 4'b0001);
        chk("wd.next_rspr", rsp_r, 12);
        chk("wd.next_err", rsp_err, 0);
        repeat (2) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
